// File: rtl/ledsgreen_pattern_driver.sv
// Green-LED pattern driver: turns the PIO control word into static, blink or
// chase LED patterns with PWM brightness. All state lives in the PIO clock
// domain; any change of the control word restarts the pattern timing.
module ledsgreen_pattern_driver #(
  parameter int NUM_LEDS = 9,
  parameter int PRESCALE = 50000,
  parameter int PWM_BITS = 4
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [31:0]         ctrl_word,
  output logic [NUM_LEDS-1:0] leds,
  output logic                step_tick,
  output logic                blink_phase,
  output logic [3:0]          chase_pos
);

  localparam int PRE_W = (PRESCALE > 2) ? $clog2(PRESCALE) : 1;

  localparam logic [1:0] MODE_BLINK = 2'b01;
  localparam logic [1:0] MODE_CHASE = 2'b10;

  logic [31:0]         ctrl_q;
  logic [PRE_W-1:0]    prescaler;
  logic [4:0]          rate_cnt;
  logic [PWM_BITS-1:0] pwm_cnt;

  logic [NUM_LEDS-1:0] led_mask;
  logic [1:0]          mode;
  logic [PWM_BITS-1:0] bright;
  logic [4:0]          rate;

  logic                restart;
  logic                base_tick;
  logic                step_hit;
  logic                pwm_on;
  logic [NUM_LEDS-1:0] pattern;

  // Single lit LED at the given chase position; positions beyond the LED
  // count shift out and give an all-dark pattern.
  function automatic logic [NUM_LEDS-1:0] one_hot(input logic [3:0] pos);
    logic [NUM_LEDS-1:0] one;
    one     = {{(NUM_LEDS-1){1'b0}}, 1'b1};
    one_hot = one << pos;
  endfunction

  assign led_mask = ctrl_q[NUM_LEDS-1:0];
  assign mode     = ctrl_q[17:16];
  assign bright   = ctrl_q[20 +: PWM_BITS];
  assign rate     = ctrl_q[28:24];

  // The full word is compared so that any host write that changes the value
  // realigns the pattern timing.
  assign restart   = (ctrl_word != ctrl_q);
  assign base_tick = (prescaler == PRE_W'(PRESCALE - 1));
  assign step_hit  = base_tick && (rate_cnt == rate);
  assign pwm_on    = (pwm_cnt <= bright);

  // Select the pattern for the current mode; mode 11 falls back to static.
  always_comb begin
    pattern = led_mask;
    case (mode)
      MODE_BLINK: pattern = blink_phase ? led_mask : '0;
      MODE_CHASE: pattern = one_hot(chase_pos) & led_mask;
      default:    pattern = led_mask;
    endcase
  end

  // Sample the control word every cycle.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ctrl_q <= '0;
    end else begin
      ctrl_q <= ctrl_word;
    end
  end

  // Base-tick prescaler and rate divider; restart wins over any tick.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      prescaler <= '0;
      rate_cnt  <= '0;
      step_tick <= 1'b0;
    end else if (restart) begin
      prescaler <= '0;
      rate_cnt  <= '0;
      step_tick <= 1'b0;
    end else begin
      prescaler <= base_tick ? '0 : prescaler + PRE_W'(1);
      if (base_tick) begin
        rate_cnt <= step_hit ? 5'd0 : rate_cnt + 5'd1;
      end
      step_tick <= step_hit;
    end
  end

  // Blink phase and chase position advance on every step, whatever the mode.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      blink_phase <= 1'b1;
      chase_pos   <= '0;
    end else if (restart) begin
      blink_phase <= 1'b1;
      chase_pos   <= '0;
    end else if (step_tick) begin
      blink_phase <= ~blink_phase;
      chase_pos   <= (chase_pos == 4'(NUM_LEDS - 1)) ? 4'd0 : chase_pos + 4'd1;
    end
  end

  // Free-running PWM counter and registered LED drive; restart leaves the
  // PWM phase alone so brightness never glitches on a host write.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pwm_cnt <= '0;
      leds    <= '0;
    end else begin
      pwm_cnt <= pwm_cnt + PWM_BITS'(1);
      leds    <= pattern & {NUM_LEDS{pwm_on}};
    end
  end

endmodule

// File: tb/tb_ledsgreen_pattern_driver.sv
// Scoreboard bench for ledsgreen_pattern_driver: stimulus pushes expected
// records, a monitor pops them on probe requests or on step_tick pulses.
module tb_ledsgreen_pattern_driver;

  logic        clk;
  logic        reset;
  logic [31:0] ctrl_word;
  logic [8:0]  leds;
  logic        step_tick;
  logic        blink_phase;
  logic [3:0]  chase_pos;

  ledsgreen_pattern_driver #(
    .NUM_LEDS(9),
    .PRESCALE(4),
    .PWM_BITS(4)
  ) dut (
    .clk(clk),
    .reset(reset),
    .ctrl_word(ctrl_word),
    .leds(leds),
    .step_tick(step_tick),
    .blink_phase(blink_phase),
    .chase_pos(chase_pos)
  );

  typedef enum {K_SNAP, K_STEP, K_PWM} kind_t;
  typedef struct {
    kind_t      kind;
    string      name;
    logic [8:0] leds;
    bit         chk;
    logic       blink;
    logic [3:0] chase;
    int         gap;
    int         cnt;
  } exp_t;

  exp_t q[$];
  int   total = 0;
  int   bad = 0;
  int   cyc = 0;
  int   last_ev = 0;
  int   pend_cnt = 0;
  bit   busy = 0;
  bit   probe = 0;
  bit   watch = 0;
  exp_t pend_item;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input int act, input int exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic snap(input string nm, input int l, input bit c, input bit b, input int cp);
    exp_t e;
    e.kind = K_SNAP; e.name = nm; e.leds = 9'(l); e.chk = c;
    e.blink = b; e.chase = 4'(cp); e.gap = -1; e.cnt = 0;
    q.push_back(e);
    probe = 1'b1;
    tick(1);
    probe = 1'b0;
  endtask

  task automatic add_step(input string nm, input int g, input bit b, input int cp, input int l);
    exp_t e;
    e.kind = K_STEP; e.name = nm; e.leds = 9'(l); e.chk = 1'b1;
    e.blink = b; e.chase = 4'(cp); e.gap = g; e.cnt = 0;
    q.push_back(e);
  endtask

  task automatic wait_done(input string nm, input int budget);
    for (int i = 0; i < budget && (q.size() != 0 || pend_cnt != 0 || busy); i++)
      @(posedge clk);
    #1;
    chk({nm, "_drain"}, q.size() + pend_cnt, 0);
    q.delete();
    pend_cnt = 0;
  endtask

  task automatic pwm_probe(input string nm, input int lit);
    exp_t e;
    e.kind = K_PWM; e.name = nm; e.leds = 9'h1FF; e.chk = 1'b0;
    e.blink = 1'b1; e.chase = 4'd0; e.gap = -1; e.cnt = lit;
    q.push_back(e);
    probe = 1'b1;
    tick(1);
    probe = 1'b0;
    wait_done(nm, 40);
  endtask

  // Monitor: pops the next expected record on each probe or watched step.
  initial begin
    exp_t it;
    forever begin
      @(negedge clk);
      if (pend_cnt > 0) begin
        pend_cnt--;
        if (pend_cnt == 0) begin
          chk({pend_item.name, "_blink"}, int'(blink_phase), int'(pend_item.blink));
          chk({pend_item.name, "_chase"}, int'(chase_pos), int'(pend_item.chase));
          chk({pend_item.name, "_leds"}, int'(leds), int'(pend_item.leds));
        end
      end
      if (probe || (watch && step_tick)) begin
        if (q.size() == 0) begin
          chk("unexpected_event", int'(step_tick), 0);
        end else begin
          it = q.pop_front();
          if (!probe) begin
            chk({it.name, "_kind"}, int'(it.kind), int'(K_STEP));
            if (it.gap >= 0) chk({it.name, "_gap"}, cyc - last_ev, it.gap);
            pend_item = it;
            pend_cnt = 2;
            last_ev = cyc;
          end else if (it.kind == K_SNAP) begin
            chk({it.name, "_leds"}, int'(leds), int'(it.leds));
            if (it.chk) begin
              chk({it.name, "_blink"}, int'(blink_phase), int'(it.blink));
              chk({it.name, "_chase"}, int'(chase_pos), int'(it.chase));
              chk({it.name, "_step"}, int'(step_tick), 0);
            end
            last_ev = cyc;
          end else if (it.kind == K_PWM) begin
            int n_on;
            int n_odd;
            busy = 1'b1;
            n_on = 0;
            n_odd = 0;
            for (int i = 0; i < 16; i++) begin
              if (i > 0) @(negedge clk);
              if (leds == 9'h1FF) n_on++;
              else if (leds != 9'h000) n_odd++;
            end
            chk({it.name, "_lit"}, n_on, it.cnt);
            chk({it.name, "_shape"}, n_odd, 0);
            last_ev = cyc;
            busy = 1'b0;
          end else begin
            chk({it.name, "_kind"}, int'(it.kind), int'(K_SNAP));
          end
        end
      end
    end
  end

  // Stimulus.
  initial begin
    int ch_leds[9];
    ch_leds = '{'h002, 'h000, 'h008, 'h010, 'h020, 'h040, 'h080, 'h000, 'h001};
    reset = 1'b1;
    ctrl_word = 32'h0;
    tick(2);

    // Reset and static pattern.
    ctrl_word = 32'h00F001AA;
    snap("rst", 'h000, 1, 1, 0);
    reset = 1'b0;
    tick(1);
    snap("static_lat", 'h000, 1, 1, 0);
    snap("static", 'h1AA, 1, 1, 0);
    tick(6);
    snap("static_hold", 'h1AA, 0, 1, 0);

    // Blink, rate 1: one step every 8 cycles, starting in the on phase.
    ctrl_word = 32'h01F101FF;
    tick(2);
    snap("blink_on", 'h1FF, 1, 1, 0);
    for (int k = 1; k <= 4; k++)
      add_step($sformatf("blink_s%0d", k), (k == 1) ? 7 : 8, (k % 2) == 0, k,
               ((k % 2) == 0) ? 'h1FF : 'h000);
    watch = 1'b1;
    wait_done("blink", 100);
    watch = 1'b0;

    // Chase with a hole in the mask, rate 0: step every 4 cycles.
    ctrl_word = 32'h00F200FB;
    tick(2);
    snap("chase0", 'h001, 1, 1, 0);
    for (int k = 1; k <= 9; k++)
      add_step($sformatf("chase_s%0d", k), (k == 1) ? 3 : 4, (k % 2) == 0, k % 9, ch_leds[k-1]);
    watch = 1'b1;
    wait_done("chase", 100);
    watch = 1'b0;

    // PWM duty.
    ctrl_word = 32'h003001FF;
    tick(2);
    pwm_probe("pwm_b3", 4);
    ctrl_word = 32'h000001FF;
    tick(2);
    pwm_probe("pwm_b0", 1);

    // Empty mask keeps LEDs dark.
    ctrl_word = 32'h00F20000;
    tick(2);
    snap("mask0_a", 'h000, 0, 1, 0);
    tick(5);
    snap("mask0_b", 'h000, 0, 1, 0);

    // Restart in the blink off phase, on the edge a step would have fired.
    ctrl_word = 32'h01F101FF;
    tick(12);
    snap("blink_off", 'h000, 1, 0, 1);
    tick(3);
    ctrl_word = 32'h01F100FF;
    tick(1);
    snap("restart", 'h000, 1, 1, 0);
    snap("restart_on", 'h0FF, 1, 1, 0);
    add_step("restart_s1", 7, 0, 1, 'h000);
    watch = 1'b1;
    wait_done("restart", 40);
    watch = 1'b0;

    // Asynchronous reset in the middle of a chase.
    ctrl_word = 32'h00F200FB;
    tick(23);
    snap("pre_rst", 'h020, 1, 0, 5);
    reset = 1'b1;
    snap("async_rst", 'h000, 1, 1, 0);
    reset = 1'b0;
    tick(2);
    snap("post_rst", 'h001, 1, 1, 0);
    add_step("post_s1", 3, 0, 1, 'h002);
    add_step("post_s2", 4, 1, 2, 'h000);
    watch = 1'b1;
    wait_done("post", 40);
    watch = 1'b0;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  // Global bound on run time.
  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule
